serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b - bin.
// One full-subtractor cell walks the operands LSB first, one bit per clock,
// under a start/busy/done handshake. Results hold until the next completion.
// Optional macro SERIAL_SUB_FLAGS_EN: when defined, the ovf and zero flags are
// computed and registered; when undefined they are tied to 0 and their logic
// is not built.
module serial_subtractor #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_cat;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [1:0]       sub_bits;
  logic             accept;
  logic             last_bit;

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] full_sub(input logic ak, input logic bk, input logic bi);
    logic d;
    logic bo;
    d  = ak ^ bk ^ bi;
    bo = (~ak & bk) | (~(ak ^ bk) & bi);
    return {bo, d};
  endfunction

  // A start is only honoured when no operation is in flight.
  assign accept   = start & (state != RUN);
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign sub_bits = full_sub(a_sr[0], b_sr[0], br);
  // New difference bit enters from the MSB side of the partial result.
  assign res_cat  = {sub_bits[0], res_sr};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: FIN always leaves after one cycle, straight into RUN on start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Bit counter: cleared on accepted start, advances once per processed bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == RUN)  cnt <= cnt + 1'b1;
  end

  // Operand and partial-result shift registers plus the running borrow.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      br     <= bin;
      res_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      br     <= sub_bits[1];
      res_sr <= res_cat[WIDTH-1:1];
    end
  end

  // Result registers: updated only as the last bit is processed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last_bit) begin
      diff <= res_cat;
      bout <= sub_bits[1];
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;

  // Operand sign bits are kept aside because the shift registers lose them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end
  end

  // Overflow and zero flags, registered alongside the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (last_bit) begin
      ovf  <= (a_msb != b_msb) & (res_cat[WIDTH-1] != a_msb);
      zero <= ~|res_cat;
    end
  end
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor. A driver issues
// directed and random operations and queues the expected result and accept
// cycle; a monitor checks handshake and outputs every cycle against that queue.
module tb_serial_subtractor;

  localparam int W = 17;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf, zero;
  logic [W-1:0] diff;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
    int           c0;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain arithmetic on the whole operands.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t r;
    int unsigned ux, uy;
    ux = x;
    uy = y;
    r.diff = W'(ux - uy - bi);
    r.bout = (ux < uy + bi);
`ifdef SERIAL_SUB_FLAGS_EN
    r.ovf  = (x[W-1] != y[W-1]) && (r.diff[W-1] != x[W-1]);
    r.zero = (r.diff == 0);
`else
    r.ovf  = 1'b0;
    r.zero = 1'b0;
`endif
    r.c0 = 0;
    return r;
  endfunction

  // Monitor: per cycle, expected busy/done follow from the oldest queued op.
  initial begin
    held = '{diff: '0, bout: 1'b0, ovf: 1'b0, zero: 1'b0, c0: 0};
    forever begin
      logic bexp, dexp;
      @(posedge clk);
      #1;
      bexp = 1'b0;
      dexp = 1'b0;
      if (q.size() > 0) begin
        bexp = (cyc >= q[0].c0) && (cyc < q[0].c0 + W);
        dexp = (cyc == q[0].c0 + W);
      end
      chk("busy", 32'(busy), 32'(bexp));
      chk("done", 32'(done), 32'(dexp));
      if (dexp) begin
        held = q.pop_front();
      end
      chk("diff", 32'(diff), 32'(held.diff));
      chk("bout", 32'(bout), 32'(held.bout));
      chk("ovf",  32'(ovf),  32'(held.ovf));
      chk("zero", 32'(zero), 32'(held.zero));
    end
  end

  // Issue an operation as soon as the DUT can accept it (IDLE or FIN).
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy === 1'b1 && n < 100);
    if (n >= 100) chk("issue_timeout", 32'(busy), 32'd0);
    a = x;
    b = y;
    bin = bi;
    start = 1'b1;
    e = model(x, y, bi);
    e.c0 = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    issue(17'd3, 17'd1, 1'b0);
    drain();
    repeat (2) @(negedge clk);
    issue(17'd1, 17'd3, 1'b0);
    drain();
    issue(17'h0FFFF, 17'h1FFFF, 1'b0);
    drain();
    repeat (1) @(negedge clk);
    // Second op lands in the FIN cycle of the first.
    issue(17'd5, 17'd5, 1'b0);
    issue(17'd5, 17'd5, 1'b1);
    drain();
    repeat (2) @(negedge clk);

    // A start while running must be ignored.
    issue(17'd9, 17'd4, 1'b0);
    repeat (4) @(negedge clk);
    a = '0;
    b = '0;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of an operation aborts it immediately.
    issue(17'd12345, 17'd678, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    q.delete();
    held = '{diff: '0, bout: 1'b0, ovf: 1'b0, zero: 1'b0, c0: 0};
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);

    // Random operations, mostly back-to-back, some with idle gaps.
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      if ($urandom_range(0, 3) == 0) y = x;
      issue(x, y, 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        drain();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
